// File: rtl/uart_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rom_loader
//  Description : Receives a program image over a UART RX line, assembles
//                little-endian 32-bit words and writes them into the
//                instruction ROM. The CPU is held in reset while a download
//                is in progress. The hold is released only after the image
//                checksum has been verified.
//
//  Frame format (bytes on the wire):
//      0xA5, N[7:0], N[15:8], N*4 data bytes, checksum (sum of data mod 256)
//
//  Ports:
//      clk         in   1   system clock
//      rst         in   1   synchronous, active-high reset
//      uart_rx_i   in   1   asynchronous serial input, idle high
//      rom_we_o    out  1   one-cycle ROM write strobe per word
//      rom_addr_o  out  32  ROM byte address, BASE_ADDR + 4*word_index
//      rom_data_o  out  32  ROM write data
//      cpu_hold_o  out  1   1 = keep CPU in reset
//      done_o      out  1   one-cycle pulse on a successful load
//      err_o       out  1   sticky error flag
//
//  Optional build macro:
//      UART_ROM_LOADER_TIMEOUT_EN - abort a load when the gap between two
//      received bytes reaches TIMEOUT_CYCLES clock cycles.
//
//  BASE_ADDR must be 4-byte aligned.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rom_loader #(
    parameter int unsigned CLK_FREQ       = 50000000,
    parameter int unsigned BAUD           = 115200,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 4096,
    parameter bit          HOLD_AT_RESET  = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx_i,
    output logic        rom_we_o,
    output logic [31:0] rom_addr_o,
    output logic [31:0] rom_data_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned c_HALF_BIT     = c_CLKS_PER_BIT / 2;
    localparam int unsigned c_CNT_W        = $clog2(c_CLKS_PER_BIT + 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF_BIT - 1);
    localparam logic [7:0]         c_SYNC_BYTE = 8'hA5;

    // ------------------------------------------------------------------
    // RX synchronizer and edge detect
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    rx_state_t          r_rx_state;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_byte;
    logic               r_byte_valid;
    logic               r_framing_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state    <= R_IDLE;
            r_bit_cnt     <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_byte        <= '0;
            r_byte_valid  <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            r_byte_valid  <= 1'b0;
            r_framing_err <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    r_bit_cnt <= '0;
                    // Edge detect (not level) so a line held low after a
                    // bad stop bit does not look like a new start bit.
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (r_bit_cnt == c_HALF_LAST) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        // Line back high at mid start bit: glitch, drop it.
                        r_rx_state <= r_rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= R_STOP;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_bit_cnt <= '0;
                        if (r_rx_sync) begin
                            r_byte       <= r_shift;
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_framing_err <= 1'b1;
                        end
                        r_rx_state <= R_IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        L_IDLE = 3'd0,
        L_LEN0 = 3'd1,
        L_LEN1 = 3'd2,
        L_DATA = 3'd3,
        L_CSUM = 3'd4
    } ld_state_t;

    ld_state_t   r_ld_state;
    logic [15:0] r_len;
    logic [15:0] r_word_index;
    logic [7:0]  r_csum;
    logic [23:0] r_word_buf;   // bytes 0..2; byte 3 goes straight to the ROM
    logic [1:0]  r_lane;
    logic        w_timeout;
    logic [15:0] w_len;

    assign w_len = {r_byte, r_len[7:0]};

`ifdef UART_ROM_LOADER_TIMEOUT_EN
    logic [31:0] r_gap_cnt;

    // The byte_valid cycle itself counts as gap cycle 0, so the counter is
    // loaded with 1 for the following cycle. The abort then becomes visible
    // on err_o exactly TIMEOUT_CYCLES cycles after the last byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt <= '0;
        end else if (r_byte_valid || r_ld_state == L_IDLE) begin
            r_gap_cnt <= 32'd1;
        end else begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
        end
    end

    assign w_timeout = (r_ld_state != L_IDLE) && !r_byte_valid &&
                       (r_gap_cnt >= TIMEOUT_CYCLES - 1);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_state   <= L_IDLE;
            rom_we_o     <= 1'b0;
            rom_addr_o   <= BASE_ADDR;
            rom_data_o   <= '0;
            cpu_hold_o   <= HOLD_AT_RESET;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            r_len        <= '0;
            r_word_index <= '0;
            r_csum       <= '0;
            r_word_buf   <= '0;
            r_lane       <= '0;
        end else begin
            rom_we_o <= 1'b0;
            done_o   <= 1'b0;
            if (r_framing_err && r_ld_state != L_IDLE) begin
                err_o      <= 1'b1;
                r_ld_state <= L_IDLE;
            end else if (w_timeout) begin
                err_o      <= 1'b1;
                r_ld_state <= L_IDLE;
            end else if (r_byte_valid) begin
                case (r_ld_state)
                    L_IDLE: begin
                        if (r_byte == c_SYNC_BYTE) begin
                            cpu_hold_o   <= 1'b1;
                            err_o        <= 1'b0;
                            r_word_index <= '0;
                            r_csum       <= '0;
                            r_lane       <= '0;
                            r_ld_state   <= L_LEN0;
                        end
                    end
                    L_LEN0: begin
                        r_len[7:0] <= r_byte;
                        r_ld_state <= L_LEN1;
                    end
                    L_LEN1: begin
                        r_len <= w_len;
                        if (32'(w_len) > MAX_WORDS) begin
                            err_o      <= 1'b1;
                            r_ld_state <= L_IDLE;
                        end else if (w_len == 16'd0) begin
                            r_ld_state <= L_CSUM;
                        end else begin
                            r_ld_state <= L_DATA;
                        end
                    end
                    L_DATA: begin
                        r_csum <= r_csum + r_byte;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_word_buf[7:0]   <= r_byte;
                            2'd1: r_word_buf[15:8]  <= r_byte;
                            2'd2: r_word_buf[23:16] <= r_byte;
                            default: begin
                                rom_we_o     <= 1'b1;
                                rom_addr_o   <= BASE_ADDR + {14'd0, r_word_index, 2'b00};
                                rom_data_o   <= {r_byte, r_word_buf};
                                r_word_index <= r_word_index + 16'd1;
                                if (r_word_index + 16'd1 == r_len) begin
                                    r_ld_state <= L_CSUM;
                                end
                            end
                        endcase
                    end
                    L_CSUM: begin
                        if (r_byte == r_csum) begin
                            done_o     <= 1'b1;
                            cpu_hold_o <= 1'b0;
                        end else begin
                            err_o <= 1'b1;
                        end
                        r_ld_state <= L_IDLE;
                    end
                    default: r_ld_state <= L_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rom_loader
//  Description : Self-checking bench for uart_rom_loader. Byte images are
//                serialised onto the RX line; a packet-level reference model
//                predicts the ROM writes, done pulses and final hold/error
//                state. Directed cases cover the boundaries, followed by
//                randomised images. Honours UART_ROM_LOADER_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rom_loader;

    localparam int unsigned CLK_FREQ  = 1000000;
    localparam int unsigned BAUD      = 100000;
    localparam int unsigned CPB       = 10;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int unsigned MAX_WORDS = 4096;
    localparam int unsigned TIMEOUT   = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        rom_we;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    uart_rom_loader #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD          (BAUD),
        .BASE_ADDR     (BASE_ADDR),
        .MAX_WORDS     (MAX_WORDS),
        .HOLD_AT_RESET (1'b0),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx_i (uart_rx),
        .rom_we_o  (rom_we),
        .rom_addr_o(rom_addr),
        .rom_data_o(rom_data),
        .cpu_hold_o(cpu_hold),
        .done_o    (done),
        .err_o     (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- observed behaviour ----------------
    logic [63:0] got_q[$];
    int          done_seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rom_we) got_q.push_back({rom_addr, rom_data});
            if (done) begin
                done_seen++;
                check("done_with_err", 32'(err), 32'd0);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  img[$];
    logic [63:0] exp_q[$];
    int          exp_done = 0;
    logic        m_err  = 1'b0;
    logic        m_hold = 1'b0;

    // Parses a complete byte image packet by packet.
    task automatic model_image();
        int         i;
        int         n;
        logic [7:0] sum;
        logic [31:0] w;
        i = 0;
        while (i < img.size()) begin
            if (img[i] != 8'hA5) begin
                i++;
                continue;
            end
            m_hold = 1'b1;
            m_err  = 1'b0;
            i++;
            if (i + 2 > img.size()) break;
            n = int'(img[i]) + 256 * int'(img[i+1]);
            i += 2;
            if (n > int'(MAX_WORDS)) begin
                m_err = 1'b1;
                continue;
            end
            sum = 8'd0;
            for (int k = 0; k < n && i + 4 <= img.size(); k++) begin
                w = {img[i+3], img[i+2], img[i+1], img[i]};
                exp_q.push_back({BASE_ADDR + 32'(4 * k), w});
                sum = sum + img[i] + img[i+1] + img[i+2] + img[i+3];
                i += 4;
            end
            if (i >= img.size()) break;
            if (img[i] == sum) begin
                exp_done++;
                m_hold = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            i++;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        done_seen = 0;
        exp_done  = 0;
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_nstrobe"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, got_q[i][63:32], exp_q[i][63:32]);
            check({tag, "_data"}, got_q[i][31:0], exp_q[i][31:0]);
        end
        check({tag, "_done"}, 32'(done_seen), 32'(exp_done));
        check({tag, "_err"},  32'(err),       32'(m_err));
        check({tag, "_hold"}, 32'(cpu_hold),  32'(m_hold));
    endtask

    task automatic run_image(input string tag);
        clear_obs();
        model_image();
        foreach (img[i]) send_byte(img[i], 1'b1, $urandom_range(0, 4));
        repeat (30) @(negedge clk);
        compare(tag);
    endtask

    task automatic load_spec_image(input logic [7:0] csum);
        img = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE};
        img.push_back(csum);
    endtask

    task automatic build_random();
        logic [7:0] b;
        int         kind;
        int         n;
        logic [7:0] sum;
        img.delete();
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            img.push_back(b);
        end
        img.push_back(8'hA5);
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            n = int'(MAX_WORDS) + 1 + $urandom_range(0, 65535 - MAX_WORDS - 1);
            img.push_back(8'(n));
            img.push_back(8'(n >> 8));
        end else begin
            n = $urandom_range(0, 5);
            img.push_back(8'(n));
            img.push_back(8'(n >> 8));
            sum = 8'd0;
            repeat (4 * n) begin
                b = 8'($urandom_range(0, 255));
                sum = sum + b;
                img.push_back(b);
            end
            img.push_back((kind <= 3) ? sum + 8'd1 : sum);
        end
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_we",   32'(rom_we), 32'd0);
        check("rst_addr", rom_addr,    BASE_ADDR);
        check("rst_data", rom_data,    32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done),   32'd0);
        check("rst_err",  32'(err),    32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // valid load; the eight data bytes sum to 0x4C mod 256
        load_spec_image(8'h4C);
        run_image("valid");
        check("valid_word0", (got_q.size() > 0) ? got_q[0][31:0] : 32'hX, 32'h12345678);
        check("valid_word1", (got_q.size() > 1) ? got_q[1][31:0] : 32'hX, 32'hDEADBEEF);

        // bad checksum, then a good load clears the error
        load_spec_image(8'h4D);
        run_image("badcsum");
        load_spec_image(8'h4C);
        run_image("recover");

        // leading junk, empty image
        img = '{8'h00, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_image("empty");

        // declared length one above the ROM depth
        img = '{8'hA5, 8'h01, 8'h10};
        run_image("toolong");

        // framing error in the middle of a word
        clear_obs();
        send_byte(8'hA5, 1'b1, 2);
        send_byte(8'h01, 1'b1, 2);
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h11, 1'b1, 2);
        send_byte(8'h22, 1'b1, 2);
        send_byte(8'h33, 1'b0, 5);
        send_byte(8'h44, 1'b1, 5);
        repeat (30) @(negedge clk);
        m_err  = 1'b1;
        m_hold = 1'b1;
        compare("framing");

        // short low glitch on an idle line
        load_spec_image(8'h4C);
        run_image("pre_glitch");
        clear_obs();
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        compare("glitch");
        load_spec_image(8'h4C);
        run_image("post_glitch");

        // reset in the middle of a load
        clear_obs();
        send_byte(8'hA5, 1'b1, 2);
        send_byte(8'h01, 1'b1, 2);
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h11, 1'b1, 2);
        send_byte(8'h22, 1'b1, 2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_we",   32'(rom_we),   32'd0);
        check("midrst_addr", rom_addr,      BASE_ADDR);
        check("midrst_data", rom_data,      32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_done", 32'(done),     32'd0);
        check("midrst_err",  32'(err),      32'd0);
        rst = 1'b0;
        m_err  = 1'b0;
        m_hold = 1'b0;
        send_byte(8'h33, 1'b1, 2);
        send_byte(8'h44, 1'b1, 2);
        repeat (30) @(negedge clk);
        compare("midrst");

        // randomised images
        for (int t = 0; t < 10; t++) begin
            build_random();
            run_image($sformatf("rand%0d", t));
        end

        // stalled load
        clear_obs();
        send_byte(8'hA5, 1'b1, 0);
        send_byte(8'h01, 1'b1, 0);
`ifdef UART_ROM_LOADER_TIMEOUT_EN
        repeat (170) @(negedge clk);
        check("timeout_early", 32'(err), 32'd0);
        repeat (60) @(negedge clk);
        check("timeout_err",  32'(err),      32'd1);
        check("timeout_hold", 32'(cpu_hold), 32'd1);
`else
        repeat (10000) @(negedge clk);
        check("stall_err",  32'(err),      32'd0);
        check("stall_hold", 32'(cpu_hold), 32'd1);
`endif
        check("stall_nstrobe", 32'(got_q.size()), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
